// File: rtl/ss_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ss_display_arbiter
// Description : Round-robin arbiter (3 requesters) with minimum hold time that
//               drives a multiplexed two-digit seven-segment display.
//               Optional digit blanking is enabled by macro SS_ARB_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_display_arbiter #(
    parameter int SCAN_BITS    = 16,
    parameter int BLANK_CYCLES = 64,
    parameter int HOLD_CYCLES  = 12000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  req,
    input  logic [23:0] data,
    output logic [2:0]  grant,
    output logic [6:0]  seg_n,
    output logic        SS_right
);

    localparam int                     c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0]    c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [SCAN_BITS-1:0]   c_blank     = SCAN_BITS'(BLANK_CYCLES);
    localparam logic [6:0]             c_dash      = 7'b0111111;
    localparam logic [6:0]             c_off       = 7'b1111111;
`ifdef SS_ARB_BLANK_EN
    localparam logic                   c_blank_en  = 1'b1;
`else
    localparam logic                   c_blank_en  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OPEN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_grant;
    logic [2:0]             w_grant_next;
    logic [1:0]             r_ptr;
    logic [1:0]             w_ptr_next;
    logic [c_hold_w-1:0]    r_hold;
    logic [c_hold_w-1:0]    w_hold_next;
    logic [7:0]             r_disp_val;
    logic [SCAN_BITS-1:0]   r_scan;
    logic [SCAN_BITS-1:0]   w_scan_next;
    logic                   r_ss_right;
    logic                   w_ss_next;
    logic [6:0]             r_seg_n;
    logic [6:0]             w_seg_next;
    logic [1:0]             w_win;
    logic                   w_arb;
    logic [1:0]             w_next_idx;

    // First requester found searching upward (mod 3) from index s.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] s);
        logic [2:0] t;
        logic [1:0] idx;
        rr_pick = s;
        for (int k = 2; k >= 0; k--) begin
            t   = {1'b0, s} + 3'(k);
            idx = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    assign w_win = rr_pick(req, r_ptr);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        w_hold_next  = r_hold;
        w_arb        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) w_arb = 1'b1;
            end
            S_HOLD: begin
                if (r_hold == '0) w_state_next = S_OPEN;
                else              w_hold_next  = r_hold - 1'b1;
            end
            S_OPEN: begin
                // Any competing request, or the owner letting go, reopens arbitration.
                if (((req & ~r_grant) != 3'b000) || ((req & r_grant) == 3'b000)) begin
                    if (|req) begin
                        w_arb = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_grant_next = 3'b000;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = 3'b000;
            end
        endcase
        if (w_arb) begin
            w_state_next = S_HOLD;
            w_grant_next = 3'b001 << w_win;
            w_ptr_next   = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
            w_hold_next  = c_hold_load;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_ptr   <= 2'd0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_ptr   <= w_ptr_next;
            r_hold  <= w_hold_next;
        end
    end

    assign w_next_idx  = w_grant_next[2] ? 2'd2 : (w_grant_next[1] ? 2'd1 : 2'd0);
    assign w_scan_next = r_scan + 1'b1;
    assign w_ss_next   = (w_scan_next == '0) ? ~r_ss_right : r_ss_right;

    // Segments track the scan/digit state that becomes visible on the same edge.
    always_comb begin
        w_seg_next = c_dash;
        if (r_grant != 3'b000)
            w_seg_next = hex_glyph(w_ss_next ? r_disp_val[7:4] : r_disp_val[3:0]);
        if (c_blank_en && (w_scan_next < c_blank))
            w_seg_next = c_off;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_disp_val <= 8'h00;
            r_scan     <= '0;
            r_ss_right <= 1'b0;
            r_seg_n    <= c_off;
        end else begin
            if (w_grant_next != 3'b000) begin
                case (w_next_idx)
                    2'd1:    r_disp_val <= data[15:8];
                    2'd2:    r_disp_val <= data[23:16];
                    default: r_disp_val <= data[7:0];
                endcase
            end
            r_scan     <= w_scan_next;
            r_ss_right <= w_ss_next;
            r_seg_n    <= w_seg_next;
        end
    end

    assign grant    = r_grant;
    assign seg_n    = r_seg_n;
    assign SS_right = r_ss_right;

endmodule
`default_nettype wire

// File: tb/tb_ss_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ss_display_arbiter
// Description : Randomised scoreboard bench for ss_display_arbiter with a
//               behavioural reference model (SCAN_BITS=4, BLANK=2, HOLD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_display_arbiter;

    localparam int c_scan_bits = 4;
    localparam int c_blank     = 2;
    localparam int c_hold      = 8;
    localparam int c_period    = 1 << c_scan_bits;
`ifdef SS_ARB_BLANK_EN
    localparam bit c_blank_en  = 1'b1;
`else
    localparam bit c_blank_en  = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [23:0] data = 24'h0;
    logic [2:0]  grant;
    logic [6:0]  seg_n;
    logic        SS_right;

    ss_display_arbiter #(
        .SCAN_BITS    (c_scan_bits),
        .BLANK_CYCLES (c_blank),
        .HOLD_CYCLES  (c_hold)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .seg_n    (seg_n),
        .SS_right (SS_right)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] g;
        logic [6:0] s;
        logic       ss;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: owner index (-1 idle), remaining hold cycles, next search start.
    int         m_owner;
    int         m_hold_left;
    bit         m_open;
    int         m_nxt;
    logic [7:0] m_disp;
    int         m_scan;
    bit         m_ss;
    logic [6:0] m_seg;

    function automatic int pick(input logic [2:0] r, input int start);
        for (int k = 0; k < 3; k++)
            if (r[(start + k) % 3]) return (start + k) % 3;
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner     = w;
        m_nxt       = (w + 1) % 3;
        m_hold_left = c_hold;
        m_open      = 1'b0;
    endtask

    task automatic model_step();
        int         prev_owner;
        logic [7:0] prev_disp;
        logic [3:0] nib;
        logic [2:0] others;
        exp_t       e;
        if (RST) begin
            m_owner = -1; m_open = 1'b0; m_nxt = 0; m_hold_left = 0;
            m_disp = 8'h00; m_scan = 0; m_ss = 1'b0; m_seg = 7'h7F;
        end else begin
            prev_owner = m_owner;
            prev_disp  = m_disp;
            m_scan = (m_scan + 1) % c_period;
            if (m_scan == 0) m_ss = ~m_ss;
            if (prev_owner < 0) begin
                m_seg = 7'b0111111;
            end else begin
                nib   = m_ss ? prev_disp[7:4] : prev_disp[3:0];
                m_seg = glyph[nib];
            end
            if (c_blank_en && m_scan < c_blank) m_seg = 7'h7F;

            if (m_owner < 0) begin
                if (req != 3'b000) model_grant(pick(req, m_nxt));
            end else if (!m_open) begin
                m_hold_left--;
                if (m_hold_left == 0) m_open = 1'b1;
            end else begin
                others = req & ~(3'b001 << m_owner);
                if (others != 3'b000 || !req[m_owner]) begin
                    if (req == 3'b000) begin
                        m_owner = -1;
                        m_open  = 1'b0;
                    end else begin
                        model_grant(pick(req, m_nxt));
                    end
                end
            end
            if (m_owner >= 0) m_disp = data[m_owner*8 +: 8];
        end
        e.g  = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        e.s  = m_seg;
        e.ss = m_ss;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req_v, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Monitor: one expected output set per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("outputs{grant,seg_n,SS_right}", {grant, seg_n, SS_right}, {e.g, e.s, e.ss});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        cycles(3);
        RST = 1'b0;

        // Full contention rotates 0 -> 1 -> 2 -> 0.
        req = 3'b111;
        @(posedge CLK); #2;
        check("first_grant", {8'h0, grant}, {8'h0, 3'b001});
        cycles(3 * (c_hold + 1) + 4);

        // Single requester with a fixed byte.
        req = 3'b010;
        data = 24'h00A500;
        cycles(4 * c_period);

        // Owner drops during hold.
        req = 3'b000;
        cycles(4);
        req = 3'b001;
        data = 24'h000037;
        cycles(3);
        req = 3'b000;
        cycles(c_hold + 4);
        check("idle_after_drop", {1'b0, seg_n, grant}, {1'b0, 7'b0111111, 3'b000});

        // Asynchronous reset mid-hold.
        req = 3'b100;
        data = 24'h5A0000;
        cycles(3);
        #2 RST = 1'b1;
        #1 check("async_reset", {grant, seg_n, SS_right}, {3'b000, 7'h7F, 1'b0});
        cycles(2);
        RST = 1'b0;
        req = 3'b110;
        @(posedge CLK); #2;
        check("grant_after_reset", {8'h0, grant}, {8'h0, 3'b010});
        cycles(2);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) req = 3'($urandom);
            data = 24'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                RST = 1'b1;
                #1 check("async_reset_rand", {grant, seg_n, SS_right}, {3'b000, 7'h7F, 1'b0});
                cycles(1);
                RST = 1'b0;
            end
            cycles(1);
        end

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ss_display_arbiter.md
SS_DISPLAY_ARBITER -- requirements
Module: ss_display_arbiter

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 16: the digit-slot length is 2^SCAN_BITS cycles.
REQ-002 SHALL have parameter BLANK_CYCLES, default 64: blanked cycles at the start of each digit slot; legal range 1 to 2^SCAN_BITS-1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 12000000: minimum grant duration in cycles; legal minimum 1.
REQ-004 SHALL have port CLK, input, 1 bit: 12 MHz system clock.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port req, input, 3 bits: req[i] high means requester i wants the display.
REQ-007 SHALL have port data, input, 24 bits: byte for requester i on data[8i+7:8i].
REQ-008 SHALL have port grant, output, 3 bits: one-hot owner of the display; all zero when idle.
REQ-009 SHALL have port seg_n, output, 7 bits: active-low segments ordered {G,F,E,D,C,B,A}.
REQ-010 SHALL have port SS_right, output, 1 bit: digit select; 1 selects the high-nibble digit.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD and OPEN, with grant as a registered output.
REQ-012 IDLE: when any req bit is high, SHALL pick a winner round-robin, assert its grant on the next edge, load the hold counter with HOLD_CYCLES-1 and enter HOLD.
REQ-013 Round-robin SHALL search upward mod 3, starting at the index after the last granted index; the pointer SHALL update on every new grant.
REQ-014 HOLD: SHALL keep grant unchanged regardless of req and decrement the counter; at count 0 SHALL enter OPEN.
REQ-015 OPEN: if the owner's req is high and no other req is high, SHALL stay in OPEN.
REQ-016 OPEN: if the owner's req is low, SHALL re-arbitrate; with no requester it SHALL go to IDLE and clear grant the same edge.
REQ-017 OPEN: if another req is high, SHALL re-arbitrate even if the owner's req is high; grant switches in one edge with no all-zero gap, and the state goes to HOLD.
REQ-018 SHALL register the granted requester's data byte into disp_val every cycle while granted, adding 1 cycle of latency.
REQ-019 SHALL register seg_n from disp_val and SS_right, so a data change reaches seg_n 2 cycles later.
REQ-020 SHALL run a free-running SCAN_BITS-bit scan counter and toggle SS_right on wrap to 0.
REQ-021 Decode SHALL be standard hex 0-F.
REQ-022 The 0 glyph SHALL be 7'b1000000, the 8 glyph 7'b0000000 and the F glyph 7'b0001110.
REQ-023 In IDLE, seg_n SHALL show a dash (7'b0111111) on both digits.
REQ-024 Simultaneous requests in IDLE SHALL be resolved by round-robin only; after reset requester 0 has top priority.
REQ-025 A req change on the cycle the hold counter reaches 0 SHALL be evaluated in OPEN on the following edge.

Reset
REQ-026 RST high SHALL immediately force the FSM to IDLE and clear grant to 3'b000.
REQ-027 RST high SHALL immediately set seg_n to 7'b1111111, SS_right to 0, the RR pointer to 0, and all counters and disp_val to 0.
REQ-028 RST asserted mid-grant SHALL discard the grant; after release the FSM SHALL arbitrate afresh from IDLE.

Configuration
REQ-029 With macro SS_ARB_BLANK_EN defined, seg_n SHALL be 7'b1111111 while the scan counter is below BLANK_CYCLES, giving anti-ghosting after each SS_right toggle.
REQ-030 Without SS_ARB_BLANK_EN, SHALL add no blanking, ignore BLANK_CYCLES, and drive seg_n with the decoded glyph every cycle.

Verification (SCAN_BITS=4, BLANK_CYCLES=2, HOLD_CYCLES=8)
REQ-031 Out of reset, req=3'b111 -> grant=3'b001 after 1 edge; after 8 cycles plus OPEN it moves to 3'b010, then 3'b100, then 3'b001.
REQ-032 req[1] only, data[15:8]=8'hA5 -> with SS_right=1 seg_n=7'b0001000 (A); with SS_right=0 seg_n=7'b0010010 (5); SS_right toggles every 16 cycles.
REQ-033 Owner drops req 2 cycles into HOLD -> grant holds for all 8 hold cycles, then clears; seg_n returns to 7'b0111111.
REQ-034 With SS_ARB_BLANK_EN defined -> seg_n=7'b1111111 for exactly 2 cycles after each SS_right toggle; with it undefined -> never blank while granted.
REQ-035 RST pulsed mid-HOLD with grant=3'b100 -> grant=0 and seg_n=7'b1111111 asynchronously; after release with req=3'b110 -> grant=3'b010.
